// File: rtl/taxi_axis_frame_limit_pkg.sv
// Shared types and helpers for the AXI-Stream frame length limiter.
package taxi_axis_frame_limit_pkg;

    typedef enum logic [0:0] {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

    // Byte count of a (zero-extended) tkeep vector.
    function automatic int unsigned keep_count(input logic [127:0] keep);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 128; i++) begin
            n += int'(keep[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI-Stream interface with source/sink modports; disabled sideband fields still exist but are ignored.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = (DATA_W > 8),
    parameter int KEEP_W  = ((DATA_W + 7) / 8),
    parameter bit LAST_EN = 1'b1,
    parameter bit ID_EN   = 1'b0,
    parameter int ID_W    = 8,
    parameter bit DEST_EN = 1'b0,
    parameter int DEST_W  = 8,
    parameter bit USER_EN = 1'b0,
    parameter int USER_W  = 1
) ();

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/taxi_axis_register.sv
// AXI-Stream register slice: REG_TYPE 0 = bypass, 1 = simple register, 2 = skid buffer (full throughput).
module taxi_axis_register #(
    parameter int REG_TYPE = 2
) (
    input  logic      clk,
    input  logic      rst,
    taxi_axis_if.snk  s_axis,
    taxi_axis_if.src  m_axis
);

    localparam int DATA_W  = s_axis.DATA_W;
    localparam bit KEEP_EN = s_axis.KEEP_EN;
    localparam int KEEP_W  = s_axis.KEEP_W;
    localparam bit LAST_EN = s_axis.LAST_EN;
    localparam bit ID_EN   = s_axis.ID_EN;
    localparam int ID_W    = s_axis.ID_W;
    localparam bit DEST_EN = s_axis.DEST_EN;
    localparam int DEST_W  = s_axis.DEST_W;
    localparam bit USER_EN = s_axis.USER_EN;
    localparam int USER_W  = s_axis.USER_W;
    localparam int PW      = DATA_W + KEEP_W + 1 + ID_W + DEST_W + USER_W;

    logic [KEEP_W-1:0] keep_in;
    logic              last_in;
    logic [ID_W-1:0]   id_in;
    logic [DEST_W-1:0] dest_in;
    logic [USER_W-1:0] user_in;
    logic [PW-1:0]     in_pkt;

    always_comb begin
        keep_in = KEEP_EN ? s_axis.tkeep : '1;
        last_in = LAST_EN ? s_axis.tlast : 1'b1;
        id_in   = ID_EN   ? s_axis.tid   : '0;
        dest_in = DEST_EN ? s_axis.tdest : '0;
        user_in = USER_EN ? s_axis.tuser : '0;
        in_pkt  = {s_axis.tdata, keep_in, last_in, id_in, dest_in, user_in};
    end

    if (REG_TYPE > 1) begin : g_skid
        logic [PW-1:0] m_pkt_reg;
        logic [PW-1:0] temp_pkt_reg;
        logic          m_valid_reg;
        logic          temp_valid_reg;
        logic          s_ready_reg;
        logic          s_ready_early;

        // Ready is registered; the temp slot absorbs the one beat accepted while the output stalls.
        assign s_ready_early = m_axis.tready || (!temp_valid_reg && (!m_valid_reg || !s_axis.tvalid));

        always_ff @(posedge clk) begin
            if (!rst) begin
                s_ready_reg    <= 1'b0;
                m_valid_reg    <= 1'b0;
                temp_valid_reg <= 1'b0;
            end else begin
                s_ready_reg <= s_ready_early;
                if (s_ready_reg) begin
                    if (m_axis.tready || !m_valid_reg) begin
                        m_valid_reg <= s_axis.tvalid;
                        m_pkt_reg   <= in_pkt;
                    end else begin
                        temp_valid_reg <= s_axis.tvalid;
                        temp_pkt_reg   <= in_pkt;
                    end
                end else if (m_axis.tready) begin
                    m_valid_reg    <= temp_valid_reg;
                    m_pkt_reg      <= temp_pkt_reg;
                    temp_valid_reg <= 1'b0;
                end
            end
        end

        assign s_axis.tready = s_ready_reg;
        assign m_axis.tvalid = m_valid_reg;
        assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = m_pkt_reg;
    end else if (REG_TYPE == 1) begin : g_simple
        logic [PW-1:0] pkt_reg;
        logic          valid_reg;

        assign s_axis.tready = rst && (!valid_reg || m_axis.tready);

        always_ff @(posedge clk) begin
            if (!rst) begin
                valid_reg <= 1'b0;
            end else if (s_axis.tready) begin
                valid_reg <= s_axis.tvalid;
                pkt_reg   <= in_pkt;
            end
        end

        assign m_axis.tvalid = valid_reg;
        assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = pkt_reg;
    end else begin : g_bypass
        assign s_axis.tready = m_axis.tready;
        assign m_axis.tvalid = s_axis.tvalid;
        assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = in_pkt;
    end

endmodule

// File: rtl/taxi_axis_frame_limit.sv
// Truncates AXI-Stream frames to cfg_max_len bytes and reports per-frame length/truncation status.
// Define TAXI_AXIS_FRAME_LIMIT_ERR_EN to flag truncated frames via tuser[0] on the forced-tlast beat.
module taxi_axis_frame_limit
    import taxi_axis_frame_limit_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,
    input  logic [LEN_W-1:0] cfg_max_len,
    output logic             status_valid,
    output logic [LEN_W-1:0] status_frame_len,
    output logic             status_trunc
);

    localparam int DATA_W  = s_axis.DATA_W;
    localparam bit KEEP_EN = s_axis.KEEP_EN;
    localparam int KEEP_W  = s_axis.KEEP_W;
    localparam bit LAST_EN = s_axis.LAST_EN;
    localparam bit ID_EN   = s_axis.ID_EN;
    localparam int ID_W    = s_axis.ID_W;
    localparam bit DEST_EN = s_axis.DEST_EN;
    localparam int DEST_W  = s_axis.DEST_W;
    localparam bit USER_EN = s_axis.USER_EN;
    localparam int USER_W  = s_axis.USER_W;

    taxi_axis_if #(
        .DATA_W(DATA_W), .KEEP_EN(KEEP_EN), .KEEP_W(KEEP_W), .LAST_EN(LAST_EN),
        .ID_EN(ID_EN), .ID_W(ID_W), .DEST_EN(DEST_EN), .DEST_W(DEST_W),
        .USER_EN(USER_EN), .USER_W(USER_W)
    ) int_axis ();

    state_t           state_reg;
    state_t           state_next;
    logic [LEN_W-1:0] count_reg;
    logic [LEN_W-1:0] max_len_reg;
    logic             frame_start_reg;

    logic [LEN_W-1:0]  max_len;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  delivered;
    logic [LEN_W:0]    beat_bytes;
    logic [LEN_W:0]    sum;
    logic [KEEP_W-1:0] keep_in;
    logic [KEEP_W-1:0] keep_mask;
    logic              over;
    logic              out_last;
    logic              beat_acc;

    // The limit in force for a frame is the live cfg on its first beat, the latched copy afterwards.
    always_comb begin
        keep_in    = KEEP_EN ? s_axis.tkeep : '1;
        max_len    = frame_start_reg ? cfg_max_len : max_len_reg;
        beat_bytes = KEEP_EN ? (LEN_W+1)'(keep_count(128'(keep_in))) : (LEN_W+1)'(KEEP_W);
        sum        = {1'b0, count_reg} + beat_bytes;
        over       = (max_len != '0) &&
                     ((sum > {1'b0, max_len}) || ((sum == {1'b0, max_len}) && !s_axis.tlast));
        remaining  = max_len - count_reg;
        for (int unsigned i = 0; i < KEEP_W; i++) begin
            keep_mask[i] = LEN_W'(i) < remaining;
        end
        out_last   = s_axis.tlast || over;
        delivered  = over ? max_len : (sum[LEN_W] ? '1 : sum[LEN_W-1:0]);
        beat_acc   = rst && (state_reg == PASS) && s_axis.tvalid && int_axis.tready;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= PASS;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            PASS: if (beat_acc && over && !s_axis.tlast) state_next = DROP;
            DROP: if (s_axis.tvalid && s_axis.tlast) state_next = PASS;
        endcase
    end

    always_comb begin
        s_axis.tready   = 1'b0;
        int_axis.tvalid = 1'b0;
        if (rst) begin
            case (state_reg)
                PASS: begin
                    s_axis.tready   = int_axis.tready;
                    int_axis.tvalid = s_axis.tvalid;
                end
                DROP: s_axis.tready = 1'b1;
            endcase
        end
        int_axis.tdata = s_axis.tdata;
        int_axis.tkeep = over ? (keep_in & keep_mask) : keep_in;
        int_axis.tlast = out_last;
        int_axis.tid   = s_axis.tid;
        int_axis.tdest = s_axis.tdest;
        int_axis.tuser = s_axis.tuser;
`ifdef TAXI_AXIS_FRAME_LIMIT_ERR_EN
        if (USER_EN && over) int_axis.tuser[0] = 1'b1;
`endif
        status_valid     = beat_acc && out_last;
        status_trunc     = beat_acc && over;
        status_frame_len = delivered;
    end

    // Any output tlast (natural or forced) closes the frame, so the next accepted beat re-latches cfg.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg       <= '0;
            max_len_reg     <= '0;
            frame_start_reg <= 1'b1;
        end else if (beat_acc) begin
            if (frame_start_reg) max_len_reg <= cfg_max_len;
            if (out_last) begin
                count_reg       <= '0;
                frame_start_reg <= 1'b1;
            end else begin
                count_reg       <= sum[LEN_W] ? '1 : sum[LEN_W-1:0];
                frame_start_reg <= 1'b0;
            end
        end
    end

    taxi_axis_register #(
        .REG_TYPE(2)
    ) reg_inst (
        .clk(clk),
        .rst(rst),
        .s_axis(int_axis),
        .m_axis(m_axis)
    );

endmodule

// File: tb/tb_taxi_axis_frame_limit.sv
// Randomized bench for taxi_axis_frame_limit against a frame-level reference model.
module tb_taxi_axis_frame_limit;
    import taxi_axis_frame_limit_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [3:0]  dest;
        logic [1:0]  user;
    } beat_t;

    typedef struct packed {
        logic [15:0] len;
        logic        trunc;
    } stat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cfg_max_len = '0;
    logic        status_valid;
    logic [15:0] status_frame_len;
    logic        status_trunc;

    taxi_axis_if #(.DATA_W(32), .KEEP_EN(1'b1), .KEEP_W(4), .ID_EN(1'b1), .ID_W(8),
                   .DEST_EN(1'b1), .DEST_W(4), .USER_EN(1'b1), .USER_W(2)) s_axis ();
    taxi_axis_if #(.DATA_W(32), .KEEP_EN(1'b1), .KEEP_W(4), .ID_EN(1'b1), .ID_W(8),
                   .DEST_EN(1'b1), .DEST_W(4), .USER_EN(1'b1), .USER_W(2)) m_axis ();

    taxi_axis_frame_limit #(.LEN_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .s_axis(s_axis),
        .m_axis(m_axis),
        .cfg_max_len(cfg_max_len),
        .status_valid(status_valid),
        .status_frame_len(status_frame_len),
        .status_trunc(status_trunc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    beat_t       fr[$];
    beat_t       exp_beats[$];
    stat_t       exp_stat[$];
    int unsigned drop_from = 32'hFFFF_FFFF;
    bit          rdy_rand  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    initial forever begin
        m_axis.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);
        #1;
    end

    always @(negedge clk) begin : mon
        beat_t a;
        stat_t s;
        if (rst && m_axis.tvalid && m_axis.tready) begin
            a = {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser};
            if (exp_beats.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_extra: got 0x%0h, expected no beat", a);
            end else begin
                check("beat", 64'(a), 64'(exp_beats.pop_front()));
            end
        end
        if (rst && status_valid) begin
            s = {status_frame_len, status_trunc};
            if (exp_stat.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL status_extra: got 0x%0h, expected no status", s);
            end else begin
                check("status", 64'(s), 64'(exp_stat.pop_front()));
            end
        end
    end

    task automatic gen_frame(input int unsigned nbytes);
        int unsigned left, n;
        beat_t b;
        fr.delete();
        left = nbytes;
        while (left > 0) begin
            n      = (left > 4) ? 4 : left;
            b.data = $urandom;
            b.keep = 4'((1 << n) - 1);
            left  -= n;
            b.last = (left == 0);
            b.id   = 8'($urandom);
            b.dest = 4'($urandom);
            b.user = 2'($urandom);
            fr.push_back(b);
        end
    endtask

    // Walk the frame byte-wise against the limit; the beat that reaches/passes it is cut to fit.
    task automatic model_frame(input int unsigned lim);
        int unsigned cum, n;
        beat_t b;
        stat_t st;
        cum = 0;
        drop_from = 32'hFFFF_FFFF;
        for (int unsigned i = 0; i < fr.size(); i++) begin
            b = fr[i];
            n = $countones(b.keep);
            if (lim != 0 && ((cum + n > lim) || (cum + n == lim && !b.last))) begin
                b.keep = b.keep & 4'((1 << (lim - cum)) - 1);
                b.last = 1'b1;
`ifdef TAXI_AXIS_FRAME_LIMIT_ERR_EN
                b.user[0] = 1'b1;
`endif
                exp_beats.push_back(b);
                st.len = 16'(lim);
                st.trunc = 1'b1;
                exp_stat.push_back(st);
                if (!fr[i].last) drop_from = i + 1;
                break;
            end
            cum += n;
            exp_beats.push_back(b);
            if (b.last) begin
                st.len = (cum > 65535) ? 16'hFFFF : 16'(cum);
                st.trunc = 1'b0;
                exp_stat.push_back(st);
            end
        end
    endtask

    task automatic send_frame(input int unsigned nsend, input int unsigned gap_max,
                              input bit chg, input logic [15:0] cfg_new);
        int unsigned gap, t;
        bit acc;
        for (int unsigned i = 0; i < nsend; i++) begin
            gap = (gap_max != 0) ? $urandom_range(0, gap_max) : 0;
            s_axis.tvalid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            s_axis.tvalid = 1'b1;
            {s_axis.tdata, s_axis.tkeep, s_axis.tlast, s_axis.tid, s_axis.tdest, s_axis.tuser} = fr[i];
            acc = 1'b0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = s_axis.tready;
                if (i >= drop_from && t == 0) check("drop_no_stall", 64'(acc), 64'd1);
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) check("accept_timeout", 64'(acc), 64'd1);
            if (chg && i == 0) cfg_max_len = cfg_new;
        end
        s_axis.tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int unsigned i = 0; i < 3000 && (exp_beats.size() != 0 || exp_stat.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(exp_beats.size() + exp_stat.size()), 64'd0);
    endtask

    initial begin
        int unsigned bb, bs, nb, lim;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tid    = '0;
        s_axis.tdest  = '0;
        s_axis.tuser  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_tready", 64'(s_axis.tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst_status_valid", 64'(status_valid), 64'd0);
        check("rst_status_trunc", 64'(status_trunc), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // max=10, 8-byte frame passes unchanged
        cfg_max_len = 16'd10;
        gen_frame(8);
        bb = exp_beats.size(); bs = exp_stat.size();
        model_frame(10);
        check("pin_a_nbeats", 64'(exp_beats.size() - bb), 64'd2);
        check("pin_a_stat", 64'(exp_stat[bs]), 64'({16'd8, 1'b0}));
        send_frame(fr.size(), 0, 1'b0, '0);
        wait_drain("drain_a");

        // max=10, 16-byte frame truncated to F,F,3
        gen_frame(16);
        bb = exp_beats.size(); bs = exp_stat.size();
        model_frame(10);
        check("pin_b_nbeats", 64'(exp_beats.size() - bb), 64'd3);
        check("pin_b_keep", 64'({exp_beats[bb].keep, exp_beats[bb+1].keep, exp_beats[bb+2].keep}), 64'h0FF3);
        check("pin_b_last", 64'({exp_beats[bb].last, exp_beats[bb+1].last, exp_beats[bb+2].last}), 64'b001);
        check("pin_b_stat", 64'(exp_stat[bs]), 64'({16'd10, 1'b1}));
`ifdef TAXI_AXIS_FRAME_LIMIT_ERR_EN
        check("pin_b_user", 64'(exp_beats[bb+2].user), 64'({fr[2].user[1], 1'b1}));
`else
        check("pin_b_user", 64'(exp_beats[bb+2].user), 64'(fr[2].user));
`endif
        send_frame(fr.size(), 0, 1'b0, '0);
        wait_drain("drain_b");

        // max=12: exact-length frame is not truncated; longer frame is
        cfg_max_len = 16'd12;
        gen_frame(12);
        bs = exp_stat.size();
        model_frame(12);
        check("pin_c_stat", 64'(exp_stat[bs]), 64'({16'd12, 1'b0}));
        send_frame(fr.size(), 0, 1'b0, '0);
        gen_frame(16);
        bb = exp_beats.size(); bs = exp_stat.size();
        model_frame(12);
        check("pin_d_beat3", 64'({exp_beats[bb+2].keep, exp_beats[bb+2].last}), 64'h1F);
        check("pin_d_stat", 64'(exp_stat[bs]), 64'({16'd12, 1'b1}));
        send_frame(fr.size(), 0, 1'b0, '0);
        wait_drain("drain_cd");

        // tlast beat overshooting the limit is still cut
        cfg_max_len = 16'd10;
        gen_frame(12);
        bs = exp_stat.size();
        model_frame(10);
        check("pin_e_stat", 64'(exp_stat[bs]), 64'({16'd10, 1'b1}));
        send_frame(fr.size(), 0, 1'b0, '0);

        // mid-frame cfg change applies from the next frame
        gen_frame(16);
        model_frame(10);
        send_frame(fr.size(), 0, 1'b1, 16'd0);
        gen_frame(16);
        bs = exp_stat.size();
        model_frame(0);
        check("pin_f_stat", 64'(exp_stat[bs]), 64'({16'd16, 1'b0}));
        send_frame(fr.size(), 0, 1'b0, '0);
        wait_drain("drain_ef");

        // unlimited, 1000 bytes
        cfg_max_len = 16'd0;
        gen_frame(1000);
        bb = exp_beats.size(); bs = exp_stat.size();
        model_frame(0);
        check("pin_g_nbeats", 64'(exp_beats.size() - bb), 64'd250);
        check("pin_g_stat", 64'(exp_stat[bs]), 64'({16'd1000, 1'b0}));
        send_frame(fr.size(), 0, 1'b0, '0);
        wait_drain("drain_g");

        // random frames, random backpressure and source gaps
        rdy_rand = 1'b1;
        for (int unsigned f = 0; f < 20; f++) begin
            nb  = $urandom_range(1, 40);
            lim = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
            cfg_max_len = 16'(lim);
            gen_frame(nb);
            model_frame(lim);
            send_frame(fr.size(), 2, 1'b1, 16'($urandom_range(0, 40)));
        end
        wait_drain("drain_rand");
        rdy_rand = 1'b0;

        // reset while dropping the tail of a truncated frame
        cfg_max_len = 16'd10;
        gen_frame(24);
        model_frame(10);
        send_frame(4, 0, 1'b0, '0);
        wait_drain("drain_pre_rst");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_state_pass", 64'(dut.state_reg), 64'(PASS));
        check("rst2_m_tvalid", 64'(m_axis.tvalid), 64'd0);
        check("rst2_s_tready", 64'(s_axis.tready), 64'd0);
        check("rst2_status_valid", 64'(status_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        gen_frame(8);
        bs = exp_stat.size();
        model_frame(10);
        check("pin_h_stat", 64'(exp_stat[bs]), 64'({16'd8, 1'b0}));
        send_frame(fr.size(), 0, 1'b0, '0);
        wait_drain("drain_post_rst");

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/taxi_axis_frame_limit.md
TAXI_AXIS_FRAME_LIMIT -- requirements
Module: taxi_axis_frame_limit

Interface
REQ-001 SHALL have parameter LEN_W, default 16, meaning the width of the frame byte counter, the limit input and the length status output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port s_axis, taxi_axis_if sink, sized by the interface: input stream.
REQ-005 SHALL have port m_axis, taxi_axis_if source, sized by the interface: output stream, same parameters as s_axis.
REQ-006 SHALL have port cfg_max_len, input, LEN_W bits: maximum output frame length in bytes; 0 means unlimited.
REQ-007 SHALL have port status_valid, output, 1 bit: one-cycle pulse per completed output frame.
REQ-008 SHALL have port status_frame_len, output, LEN_W bits: bytes delivered in that frame.
REQ-009 SHALL have port status_trunc, output, 1 bit: frame was truncated; qualified by status_valid.

Function
REQ-010 SHALL forward s_axis beats through an output register stage with 1-cycle latency and full throughput, with no loss, duplication or reordering under any m_axis.tready pattern.
REQ-011 SHALL count bytes per beat as popcount(tkeep) when KEEP_EN=1, and as KEEP_W when KEEP_EN=0; input tkeep is contiguous from bit 0.
REQ-012 SHALL latch cfg_max_len on the first accepted beat of each frame; changes mid-frame SHALL take effect from the next frame.
REQ-013 SHALL use a two-state FSM: PASS (forward) and DROP (discard until input tlast).
REQ-014 SHALL, in PASS, set s_axis.tready equal to the ready of the internal register stage.
REQ-015 SHALL, in DROP, hold s_axis.tready=1, emit no output beats, and return to PASS on an accepted beat with tlast=1.
REQ-016 SHALL, in PASS, when a beat would make the running count reach or exceed a non-zero limit without input tlast, mask tkeep to the remaining bytes, force tlast=1, go to DROP, and report status_trunc=1.
REQ-017 SHALL NOT treat a frame as truncated when it ends with input tlast exactly at the limit.
REQ-018 SHALL pulse status_valid in the cycle the output tlast beat is accepted by the register stage, with status_frame_len equal to the delivered byte count.
REQ-019 SHALL saturate the byte counter at 2^LEN_W-1 when the limit is 0.
REQ-020 SHALL pass tid, tdest and tuser unchanged, except as stated in REQ-026.

Reset
REQ-021 SHALL, while rst=0 at a clk edge, set the FSM to PASS, clear the byte counter, and drive m_axis.tvalid=0, status_valid=0 and status_trunc=0.
REQ-022 SHALL discard a frame that is in flight when reset is asserted; the first beat after reset releases SHALL be treated as the start of a frame.
REQ-023 SHALL drive s_axis.tready=0 during reset.

Configuration
REQ-024 SHALL compile the error marking in only when the macro TAXI_AXIS_FRAME_LIMIT_ERR_EN is defined.
REQ-025 SHALL, without the macro, leave tuser untouched on truncated frames.
REQ-026 SHALL, with the macro and USER_EN=1, OR 1 into tuser[0] on the forced-tlast beat.

Structure
REQ-027 SHALL place the FSM state enum (PASS, DROP) in the shared package taxi_axis_frame_limit_pkg.
REQ-028 SHALL implement the output register stage as one instance of the sub-module taxi_axis_register with REG_TYPE=2, fed from an internal taxi_axis_if.
REQ-029 SHALL keep the counting, masking and FSM logic in taxi_axis_frame_limit itself.

Verification (DATA_W=32, KEEP_W=4)
REQ-030 SHALL cover: max=10, 8-byte frame (keep F,F) -> unchanged; status len 8, trunc 0.
REQ-031 SHALL cover: max=10, 16-byte frame (4 beats) -> output keep F,F,3 with tlast on beat 3; beat 4 consumed and dropped; status len 10, trunc 1; tuser[0]=1 on beat 3 only with the macro.
REQ-032 SHALL cover: max=12, 12-byte frame with tlast on beat 3 -> unchanged, trunc 0; max=12, 16-byte frame -> beat 3 keep F with tlast forced, trunc 1.
REQ-033 SHALL cover: 20 random frames with m_axis.tready toggling 50% and s_axis.tvalid gapped -> output equals the reference model, no stalls in DROP.
REQ-034 SHALL cover: reset asserted in DROP mid-frame -> m_axis.tvalid=0, FSM in PASS; the next 8-byte frame passes intact.
REQ-035 SHALL cover: max=0, 1000-byte frame -> unmodified; status len 1000, trunc 0.
